permutation: RTL and testbench



---
 rtl/permutation_pkg.sv | 34 +++
 rtl/permutation_layers.sv | 57 +++++
 rtl/permutation.sv | 44 ++++
 tb/tb_permutation.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/permutation_pkg.sv
// Shared ASCON definitions: state geometry, round-constant table and S-box table.
// The round datapath modules and the permutation top all import this package.
package ascon_pack;

  // x0..x4 live at indices [0]..[4], each one 64-bit word.
  typedef logic [4:0][63:0] type_state;

  localparam int unsigned NUM_ROUNDS = 12;

  localparam logic [7:0] ROUND_CONST [NUM_ROUNDS] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam logic [4:0] SBOX_TABLE [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // Round indices 12..15 fall outside the table and add nothing.
  function automatic logic [7:0] round_const(input logic [3:0] round);
    logic [7:0] c;
    c = 8'h00;
    if (round < 4'd12) c = ROUND_CONST[round];
    return c;
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/permutation_layers.sv
// Combinational round layers of the ASCON permutation: constant addition,
// S-box substitution (64 parallel 5-bit S-boxes) and linear diffusion.
module constant_addition
  import ascon_pack::*;
(
  input  type_state    x_i,
  input  logic [3:0]   round_i,
  output type_state    x_o
);
  always_comb begin
    x_o          = x_i;
    x_o[2][7:0]  = x_i[2][7:0] ^ round_const(round_i);
  end
endmodule

module sbox
  import ascon_pack::*;
(
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);
  assign y_o = SBOX_TABLE[x_i];
endmodule

module substitution_layer
  import ascon_pack::*;
(
  input  type_state x_i,
  output type_state x_o
);
  // Each bit column j forms one 5-bit S-box word with x0 as the MSB.
  for (genvar j = 0; j < 64; j++) begin : g_col
    logic [4:0] col_out;
    sbox u_sbox (
      .x_i ({x_i[0][j], x_i[1][j], x_i[2][j], x_i[3][j], x_i[4][j]}),
      .y_o (col_out)
    );
    assign x_o[0][j] = col_out[4];
    assign x_o[1][j] = col_out[3];
    assign x_o[2][j] = col_out[2];
    assign x_o[3][j] = col_out[1];
    assign x_o[4][j] = col_out[0];
  end
endmodule

module diffusion_layer
  import ascon_pack::*;
(
  input  type_state x_i,
  output type_state x_o
);
  assign x_o[0] = x_i[0] ^ rotr64(x_i[0], 19) ^ rotr64(x_i[0], 28);
  assign x_o[1] = x_i[1] ^ rotr64(x_i[1], 61) ^ rotr64(x_i[1], 39);
  assign x_o[2] = x_i[2] ^ rotr64(x_i[2],  1) ^ rotr64(x_i[2],  6);
  assign x_o[3] = x_i[3] ^ rotr64(x_i[3], 10) ^ rotr64(x_i[3], 17);
  assign x_o[4] = x_i[4] ^ rotr64(x_i[4],  7) ^ rotr64(x_i[4], 41);
endmodule

// File: rtl/permutation.sv
// One ASCON round per clock: round input is either a fresh state or the
// registered state; the result of pL(pS(pC(.))) is captured every edge.
module permutation
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       select_i,
  input  type_state  permutation_i,
  input  logic [3:0] roundp_i,
  output type_state  permutation_o
);
  type_state state_q;
  type_state state_d;
  type_state round_in;
  type_state after_pc;
  type_state after_ps;

  assign round_in = select_i ? permutation_i : state_q;

  constant_addition u_pc (
    .x_i     (round_in),
    .round_i (roundp_i),
    .x_o     (after_pc)
  );

  substitution_layer u_ps (
    .x_i (after_pc),
    .x_o (after_ps)
  );

  diffusion_layer u_pl (
    .x_i (after_ps),
    .x_o (state_d)
  );

  // resetb_i is active-high despite its name.
  always_ff @(posedge clock_i or posedge resetb_i) begin
    if (resetb_i) state_q <= '0;
    else          state_q <= state_d;
  end

  assign permutation_o = state_q;
endmodule

// File: tb/tb_permutation.sv
// Self-checking bench for the ASCON round datapath against a word/bit-level
// reference model of one ASCON round.
module tb_permutation;
  typedef logic [4:0][63:0] st_t;

  logic       clk;
  logic       rst;
  logic       sel;
  st_t        pin;
  logic [3:0] rnd;
  st_t        pout;

  int n_checks = 0;
  int n_pass   = 0;

  st_t model_state;
  st_t gold [12];
  st_t init_st;
  logic [319:0] exp_q [$];

  permutation dut (
    .clock_i       (clk),
    .resetb_i      (rst),
    .select_i      (sel),
    .permutation_i (pin),
    .roundp_i      (rnd),
    .permutation_o (pout)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  localparam logic [4:0] SB [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t ref_round(input st_t s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    logic [4:0]  o;
    st_t         res;
    for (int k = 0; k < 5; k++) x[k] = s[k];
    // Constant c[i] has high nibble 15-i and low nibble i.
    if (r < 12) x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
    for (int k = 0; k < 5; k++) y[k] = '0;
    for (int j = 0; j < 64; j++) begin
      for (int k = 0; k < 5; k++) v[4-k] = x[k][j];
      o = SB[v];
      for (int k = 0; k < 5; k++) y[k][j] = o[4-k];
    end
    res[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
    res[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
    res[2] = y[2] ^ ror(y[2],  1) ^ ror(y[2],  6);
    res[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
    res[4] = y[4] ^ ror(y[4],  7) ^ ror(y[4], 41);
    return res;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom(), $urandom()};
    return s;
  endfunction

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---------------- drivers ----------------
  // Apply one round at the falling edge, predict it, check after the rising edge.
  task automatic do_round(input string tag, input logic s, input st_t st, input int r);
    st_t src;
    @(negedge clk);
    sel = s;
    pin = st;
    rnd = 4'(r);
    src = s ? st : model_state;
    model_state = ref_round(src, r);
    exp_q.push_back(model_state);
    @(posedge clk);
    #1;
    check_eq(tag, pout, exp_q.pop_front());
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2;
    sel = $urandom_range(0, 1);
    pin = rand_state();
    rnd = 4'($urandom_range(0, 15));
    rst = 1'b1;
    model_state = '0;
    #1;
    check_eq(tag, pout, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_p12(input string tag, input logic keep_gold);
    for (int i = 0; i < 12; i++) begin
      do_round(tag, (i == 0), init_st, i);
      if (keep_gold) gold[i] = model_state;
      else check_eq({tag, "_gold"}, pout, gold[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    sel = 1'b1;
    pin = rand_state();
    rnd = 4'($urandom_range(0, 15));
    model_state = '0;
    init_st[0] = 64'h80400c0600000000;
    init_st[1] = 64'h0001020304050607;
    init_st[2] = 64'h08090a0b0c0d0e0f;
    init_st[3] = 64'h0011223344556677;
    init_st[4] = 64'h8899aabbccddeeff;

    #3;
    check_eq("reset_immediate", pout, '0);
    @(posedge clk);
    #1;
    check_eq("reset_held_edge", pout, '0);
    @(negedge clk);
    rst = 1'b0;

    // Zero state, round 0, with known closed-form words.
    do_round("zero_r0", 1'b1, '0, 0);
    check_eq("zero_r0_x0", 320'(pout[0]), 320'(64'h001e0f00000000f0));
    check_eq("zero_r0_x4", 320'(pout[4]), '0);

    // Every constant index, including the out-of-table ones.
    for (int k = 0; k < 16; k++) do_round($sformatf("const_k%0d", k), 1'b1, '0, k);

    run_p12("p12", 1'b1);
    // Six-round variant uses the tail of the constant table.
    for (int i = 6; i < 12; i++) do_round("p6", (i == 6), rand_state(), i);

    // Restart mid-chain discards the previous state.
    for (int i = 0; i < 4; i++) do_round("chain", (i == 0), rand_state(), i);
    do_round("restart", 1'b1, rand_state(), 4);
    for (int i = 5; i < 8; i++) do_round("after_restart", 1'b0, rand_state(), i);

    // Asynchronous reset mid-chain, then golden replay.
    for (int i = 0; i < 5; i++) do_round("pre_reset", (i == 0), init_st, i);
    pulse_reset("reset_mid_chain");
    run_p12("replay", 1'b0);

    // Randomized select / round / data.
    for (int n = 0; n < 200; n++)
      do_round("random", ($urandom_range(0, 7) == 0), rand_state(), $urandom_range(0, 15));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
